// File: rtl/wb_commit.sv
// Writeback/commit stage: GPR file, HI/LO, LLbit and commit trace registers.
// Optional macro WB_RF_BYPASS_EN forwards the same-cycle write to the read ports.

`ifndef ALUOp
`define ALUOp 7:0
`endif

module wb_commit #(
    parameter int unsigned RF_DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   wb_pc,
    input  logic [`ALUOp] wb_aluop,
    input  logic [31:0]   wb_alures,
    input  logic [31:0]   wb_mulres,
    input  logic [31:0]   wb_m_vaddr,
    input  logic [31:0]   wb_m_rdata,
    input  logic [3:0]    wb_wreg,
    input  logic [4:0]    wb_wraddr,
    input  logic          wb_hilo_wen,
    input  logic [63:0]   wb_hilo,
    input  logic          wb_llb_wen,
    input  logic          wb_llbit,
    input  logic          exc_llb_clr,
    input  logic [4:0]    rd_addr1,
    input  logic [4:0]    rd_addr2,
    output logic [31:0]   rd_data1,
    output logic [31:0]   rd_data2,
    output logic [31:0]   hi,
    output logic [31:0]   lo,
    output logic          llbit,
    output logic [31:0]   dbg_pc,
    output logic [3:0]    dbg_wen,
    output logic [4:0]    dbg_wnum,
    output logic [31:0]   dbg_wdata
);

    localparam logic [`ALUOp] OpLb  = 'h20;
    localparam logic [`ALUOp] OpLh  = 'h21;
    localparam logic [`ALUOp] OpLwl = 'h22;
    localparam logic [`ALUOp] OpLw  = 'h23;
    localparam logic [`ALUOp] OpLbu = 'h24;
    localparam logic [`ALUOp] OpLhu = 'h25;
    localparam logic [`ALUOp] OpLwr = 'h26;
    localparam logic [`ALUOp] OpMul = 'h30;

    logic [31:0] gpr_q [RF_DEPTH];
    logic [31:0] hi_q, lo_q;
    logic        llbit_q;
    logic [31:0] dbg_pc_q, dbg_wdata_q;
    logic [3:0]  dbg_wen_q;
    logic [4:0]  dbg_wnum_q;

    logic [1:0]  k;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] wdata;
    logic [31:0] wr_old;
    logic [31:0] wr_val;
    logic        wr_hit;
    logic        unused_vaddr;

    assign unused_vaddr = ^wb_m_vaddr[31:2];

    assign k       = wb_m_vaddr[1:0];
    assign ld_byte = wb_m_rdata[{k, 3'b000} +: 8];
    assign ld_half = k[1] ? wb_m_rdata[31:16] : wb_m_rdata[15:0];

    always_comb begin
        wdata = wb_alures;
        case (wb_aluop)
            OpLb:    wdata = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   wdata = {24'h0, ld_byte};
            OpLh:    wdata = {{16{ld_half[15]}}, ld_half};
            OpLhu:   wdata = {16'h0, ld_half};
            OpLw:    wdata = wb_m_rdata;
            // LWL/LWR align the word so only the enabled bytes land in place
            OpLwl:   wdata = wb_m_rdata << {~k, 3'b000};
            OpLwr:   wdata = wb_m_rdata >> {k, 3'b000};
            OpMul:   wdata = wb_mulres;
            default: wdata = wb_alures;
        endcase
    end

    assign wr_old = gpr_q[wb_wraddr];
    assign wr_hit = (wb_wraddr != 5'd0) && (wb_wreg != 4'h0);

    always_comb begin
        wr_val = wr_old;
        for (int i = 0; i < 4; i++) begin
            if (wb_wreg[i]) begin
                wr_val[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        if (wb_wraddr == 5'd0) begin
            wr_val = '0;
        end
    end

    always_comb begin
        rd_data1 = '0;
        if (!rst && rd_addr1 != 5'd0) begin
            rd_data1 = gpr_q[rd_addr1];
`ifdef WB_RF_BYPASS_EN
            if (wr_hit && rd_addr1 == wb_wraddr) begin
                rd_data1 = wr_val;
            end
`endif
        end
    end

    always_comb begin
        rd_data2 = '0;
        if (!rst && rd_addr2 != 5'd0) begin
            rd_data2 = gpr_q[rd_addr2];
`ifdef WB_RF_BYPASS_EN
            if (wr_hit && rd_addr2 == wb_wraddr) begin
                rd_data2 = wr_val;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wr_hit) begin
            gpr_q[wb_wraddr] <= wr_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            llbit_q <= 1'b0;
        end else begin
            if (wb_hilo_wen) begin
                hi_q <= wb_hilo[63:32];
                lo_q <= wb_hilo[31:0];
            end
            // An exception/ERET commit always kills the reservation
            if (exc_llb_clr) begin
                llbit_q <= 1'b0;
            end else if (wb_llb_wen) begin
                llbit_q <= wb_llbit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_pc_q    <= '0;
            dbg_wen_q   <= '0;
            dbg_wnum_q  <= '0;
            dbg_wdata_q <= '0;
        end else begin
            dbg_pc_q    <= wb_pc;
            dbg_wen_q   <= (wb_wraddr == 5'd0) ? 4'h0 : wb_wreg;
            dbg_wnum_q  <= wb_wraddr;
            dbg_wdata_q <= wr_val;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign llbit     = llbit_q;
    assign dbg_pc    = dbg_pc_q;
    assign dbg_wen   = dbg_wen_q;
    assign dbg_wnum  = dbg_wnum_q;
    assign dbg_wdata = dbg_wdata_q;

endmodule

// File: tb/tb_wb_commit.sv
// Randomized plus directed bench for wb_commit against a behavioural model.

module tb_wb_commit;

    localparam logic [7:0] OpLb  = 8'h20;
    localparam logic [7:0] OpLh  = 8'h21;
    localparam logic [7:0] OpLwl = 8'h22;
    localparam logic [7:0] OpLw  = 8'h23;
    localparam logic [7:0] OpLbu = 8'h24;
    localparam logic [7:0] OpLhu = 8'h25;
    localparam logic [7:0] OpLwr = 8'h26;
    localparam logic [7:0] OpMul = 8'h30;
    localparam logic [7:0] OpAdd = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_pc, wb_alures, wb_mulres, wb_m_vaddr, wb_m_rdata;
    logic [7:0]  wb_aluop;
    logic [3:0]  wb_wreg;
    logic [4:0]  wb_wraddr;
    logic        wb_hilo_wen;
    logic [63:0] wb_hilo;
    logic        wb_llb_wen, wb_llbit, exc_llb_clr;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2, hi, lo, dbg_pc, dbg_wdata;
    logic        llbit;
    logic [3:0]  dbg_wen;
    logic [4:0]  dbg_wnum;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Behavioural state
    logic [31:0] m_regs [32];
    logic [31:0] m_hi, m_lo, m_pc, m_wdata;
    logic        m_llbit;
    logic [3:0]  m_wen;
    logic [4:0]  m_wnum;

    logic [7:0]  op_list [10];

    wb_commit #(.RF_DEPTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_pc       (wb_pc),
        .wb_aluop    (wb_aluop),
        .wb_alures   (wb_alures),
        .wb_mulres   (wb_mulres),
        .wb_m_vaddr  (wb_m_vaddr),
        .wb_m_rdata  (wb_m_rdata),
        .wb_wreg     (wb_wreg),
        .wb_wraddr   (wb_wraddr),
        .wb_hilo_wen (wb_hilo_wen),
        .wb_hilo     (wb_hilo),
        .wb_llb_wen  (wb_llb_wen),
        .wb_llbit    (wb_llbit),
        .exc_llb_clr (exc_llb_clr),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .hi          (hi),
        .lo          (lo),
        .llbit       (llbit),
        .dbg_pc      (dbg_pc),
        .dbg_wen     (dbg_wen),
        .dbg_wnum    (dbg_wnum),
        .dbg_wdata   (dbg_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] result_of();
        int          kk;
        logic [31:0] b, h;
        kk = int'(wb_m_vaddr[1:0]);
        b  = (wb_m_rdata >> (8 * kk)) & 32'hFF;
        h  = (wb_m_rdata >> (16 * (kk / 2))) & 32'hFFFF;
        case (wb_aluop)
            OpLb:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            OpLbu:   return b;
            OpLh:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            OpLhu:   return h;
            OpLw:    return wb_m_rdata;
            OpLwl:   return wb_m_rdata << (8 * (3 - kk));
            OpLwr:   return wb_m_rdata >> (8 * kk);
            OpMul:   return wb_mulres;
            default: return wb_alures;
        endcase
    endfunction

    function automatic logic [31:0] new_value();
        logic [31:0] v, r;
        if (wb_wraddr == 0) return 32'h0;
        v = m_regs[wb_wraddr];
        r = result_of();
        for (int i = 0; i < 4; i++) begin
            if (wb_wreg[i]) v[8*i +: 8] = r[8*i +: 8];
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (rst || a == 0) return 32'h0;
`ifdef WB_RF_BYPASS_EN
        if (a == wb_wraddr && wb_wreg != 0) return new_value();
`endif
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_hi = 0; m_lo = 0; m_llbit = 0;
        m_pc = 0; m_wen = 0; m_wnum = 0; m_wdata = 0;
    endtask

    task automatic model_commit();
        logic [31:0] v;
        v       = new_value();
        m_pc    = wb_pc;
        m_wen   = (wb_wraddr == 0) ? 4'h0 : wb_wreg;
        m_wnum  = wb_wraddr;
        m_wdata = v;
        if (wb_wraddr != 0) m_regs[wb_wraddr] = v;
        if (wb_hilo_wen) begin
            m_hi = wb_hilo[63:32];
            m_lo = wb_hilo[31:0];
        end
        if (exc_llb_clr) m_llbit = 1'b0;
        else if (wb_llb_wen) m_llbit = wb_llbit;
    endtask

    task automatic set_idle();
        wb_pc = 0; wb_aluop = OpAdd; wb_alures = 0; wb_mulres = 0;
        wb_m_vaddr = 0; wb_m_rdata = 0; wb_wreg = 0; wb_wraddr = 0;
        wb_hilo_wen = 0; wb_hilo = 0; wb_llb_wen = 0; wb_llbit = 0;
        exc_llb_clr = 0; rd_addr1 = 0; rd_addr2 = 0;
    endtask

    // Inputs are applied just after a posedge; reads are checked mid-cycle,
    // registered state just after the next posedge.
    task automatic tick();
        #4;
        check("rd_data1", {32'h0, rd_data1}, {32'h0, exp_read(rd_addr1)});
        check("rd_data2", {32'h0, rd_data2}, {32'h0, exp_read(rd_addr2)});
        @(posedge clk);
        if (rst) model_reset();
        else model_commit();
        #1;
        check("dbg_pc", {32'h0, dbg_pc}, {32'h0, m_pc});
        check("dbg_wen", {60'h0, dbg_wen}, {60'h0, m_wen});
        check("dbg_wnum", {59'h0, dbg_wnum}, {59'h0, m_wnum});
        check("dbg_wdata", {32'h0, dbg_wdata}, {32'h0, m_wdata});
        check("hilo", {hi, lo}, {m_hi, m_lo});
        check("llbit", {63'h0, llbit}, {63'h0, m_llbit});
    endtask

    task automatic write_alu(input logic [4:0] a, input logic [31:0] v, input logic [3:0] we);
        set_idle();
        wb_aluop = OpAdd; wb_alures = v; wb_wraddr = a; wb_wreg = we; wb_pc = 32'h1000;
        tick();
    endtask

    initial begin
        op_list = '{OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLwl, OpLwr, OpMul, OpAdd, 8'h55};
        model_reset();
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // A write presented while in reset must be dropped
        wb_aluop = OpAdd; wb_alures = 32'hCAFEF00D; wb_wraddr = 5'd3; wb_wreg = 4'hF;
        rd_addr1 = 5'd3;
        tick();
        rst = 1'b0;
        set_idle();
        rd_addr1 = 5'd3;
        tick();
        check("reset_r3", {32'h0, rd_data1}, 64'h0);

        // LB sign extension
        set_idle();
        wb_aluop = OpLb; wb_m_vaddr = 32'h1000_0003; wb_m_rdata = 32'h80AABBCC;
        wb_wreg = 4'hF; wb_wraddr = 5'd5;
        tick();
        check("lb_dbg", {32'h0, dbg_wdata}, 64'hFFFFFF80);
        set_idle(); rd_addr1 = 5'd5;
        #4 check("lb_r5", {32'h0, rd_data1}, 64'hFFFFFF80);
        #1 @(posedge clk); #1;

        // LWL / LWR partial merges
        write_alu(5'd6, 32'h11223344, 4'hF);
        set_idle();
        wb_aluop = OpLwl; wb_m_vaddr = 32'h1; wb_m_rdata = 32'hAABBCCDD;
        wb_wreg = 4'b1100; wb_wraddr = 5'd6;
        tick();
        check("lwl_r6", {32'h0, dbg_wdata}, 64'hCCDD3344);
        set_idle();
        wb_aluop = OpLwr; wb_m_vaddr = 32'h2; wb_m_rdata = 32'hAABBCCDD;
        wb_wreg = 4'b0011; wb_wraddr = 5'd6; rd_addr2 = 5'd6;
        tick();
        check("lwr_r6", {32'h0, dbg_wdata}, 64'hCCDDAABB);

        // r0 stays zero
        set_idle();
        wb_alures = 32'hDEADBEEF; wb_wreg = 4'hF; wb_wraddr = 5'd0; rd_addr1 = 5'd0;
        tick();
        check("r0_wen", {60'h0, dbg_wen}, 64'h0);
        check("r0_read", {32'h0, rd_data1}, 64'h0);

        // Same-cycle read of the register being written
        set_idle();
        wb_alures = 32'h12345678; wb_wreg = 4'hF; wb_wraddr = 5'd7; rd_addr2 = 5'd7;
        #4;
`ifdef WB_RF_BYPASS_EN
        check("byp_same", {32'h0, rd_data2}, 64'h12345678);
`else
        check("byp_same", {32'h0, rd_data2}, 64'h0);
`endif
        @(posedge clk); model_commit(); #1;
        set_idle(); rd_addr2 = 5'd7;
        #4 check("byp_next", {32'h0, rd_data2}, 64'h12345678);
        #1 @(posedge clk); #1;

        // LLbit: clear wins over set
        set_idle();
        wb_llb_wen = 1; wb_llbit = 1; exc_llb_clr = 1;
        tick();
        check("llb_clr", {63'h0, llbit}, 64'h0);
        set_idle();
        wb_llb_wen = 1; wb_llbit = 1;
        tick();
        check("llb_set", {63'h0, llbit}, 64'h1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            set_idle();
            wb_pc       = $urandom;
            wb_aluop    = op_list[$urandom_range(0, 9)];
            wb_alures   = $urandom;
            wb_mulres   = $urandom;
            wb_m_vaddr  = $urandom;
            wb_m_rdata  = $urandom;
            wb_wreg     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            wb_wraddr   = 5'($urandom);
            wb_hilo_wen = 1'($urandom);
            wb_hilo     = {$urandom, $urandom};
            wb_llb_wen  = 1'($urandom);
            wb_llbit    = 1'($urandom);
            exc_llb_clr = ($urandom_range(0, 3) == 0);
            rd_addr1    = ($urandom_range(0, 3) == 0) ? wb_wraddr : 5'($urandom);
            rd_addr2    = ($urandom_range(0, 3) == 0) ? wb_wraddr : 5'($urandom);
            tick();
        end

        // HI/LO write followed by a mid-cycle reset that kills an in-flight write
        write_alu(5'd9, 32'h99999999, 4'hF);
        set_idle();
        wb_hilo_wen = 1; wb_hilo = 64'h0000000100000002;
        tick();
        check("hilo_set", {hi, lo}, 64'h0000000100000002);
        set_idle();
        wb_alures = 32'h5A5A5A5A; wb_wreg = 4'hF; wb_wraddr = 5'd9; rd_addr1 = 5'd9;
        #3 rst = 1'b1;
        #1;
        check("rst_hilo", {hi, lo}, 64'h0);
        check("rst_rd", {32'h0, rd_data1}, 64'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            #1 check("rst_gpr", {32'h0, rd_data1}, 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 Parameter RF_DEPTH, default 32, meaning number of GPRs (fixed at 32; address 5 bits).
REQ-002 The clock and reset signals SHALL be clk (input, 1 bit) and rst (input, 1 bit); rst is asynchronous and active-high.
REQ-003 wb_pc  in  32  PC of the retiring instruction.
REQ-004 wb_aluop  in  `ALUOp  operation code; the width is set by the core defines.
REQ-005 wb_alures / wb_mulres / wb_m_vaddr / wb_m_rdata  in  32 each  ALU result, multiplier result, load address, raw load word.
REQ-006 wb_wreg  in  4  per-byte GPR write enable; wb_wraddr  in  5  destination GPR.
REQ-007 wb_hilo_wen  in  1; wb_hilo  in  64  HI/LO write.
REQ-008 wb_llb_wen  in  1; wb_llbit  in  1  LLbit write.
REQ-009 exc_llb_clr  in  1  exception/ERET commit; this signal clears LLbit.
REQ-010 rd_addr1, rd_addr2  in  5 each; rd_data1, rd_data2  out  32 each  ID-stage GPR read ports.
REQ-011 hi, lo  out  32 each; llbit  out  1  architectural state.
REQ-012 dbg_pc  out  32; dbg_wen  out  4; dbg_wnum  out  5; dbg_wdata  out  32  commit trace.

Function
REQ-013 Result select SHALL work as follows: load ops (LB, LBU, LH, LHU, LW, LWL, LWR) use the extracted load data; MUL-class ops use wb_mulres; all other ops use wb_alures.
REQ-014 Load extraction SHALL be little-endian, with k=wb_m_vaddr[1:0]:
- LB/LBU: byte k, sign-extended or zero-extended.
- LH/LHU: halfword k[1], sign-extended or zero-extended.
- LW: the full word.
- LWL: rdata shifted left by 8*(3-k).
- LWR: rdata shifted right by 8*k.
REQ-015 GPR write SHALL occur at posedge clk, per byte i where wb_wreg[i]=1, with wdata[8i+7:8i]; bytes not enabled SHALL retain their old value (this is how LWL/LWR merge).
REQ-016 Writes to GPR 0 SHALL be discarded; reads of address 0 SHALL return 0.
REQ-017 GPR reads SHALL be combinational from the array (bypass behaviour per REQ-026/027).
REQ-018 When wb_hilo_wen=1, the block SHALL update {hi,lo} <= wb_hilo at posedge clk.
REQ-019 When wb_llb_wen=1, the block SHALL update llbit <= wb_llbit; if exc_llb_clr=1 in the same cycle, exc_llb_clr SHALL win and llbit SHALL become 0.
REQ-020 The trace registers SHALL latch every cycle, with 1-cycle latency:
- dbg_pc <= wb_pc
- dbg_wen <= (wb_wraddr==0 ? 0 : wb_wreg)
- dbg_wnum <= wb_wraddr
- dbg_wdata <= the merged post-write register value
REQ-021 A bubble (wb_wreg=0, wb_hilo_wen=0, wb_llb_wen=0) SHALL leave all state unchanged and SHALL produce dbg_wen=0 on the next cycle.
REQ-022 There SHALL be no stall input; upstream bubbles guarantee that each cycle's inputs commit exactly once.

Reset
REQ-023 On rst=1, asynchronously, the block SHALL clear all GPRs, hi, lo, llbit, dbg_pc, dbg_wen, dbg_wnum and dbg_wdata to 0.
REQ-024 While rst=1, rd_data1/rd_data2 SHALL read 0, and writes presented during reset SHALL be ignored.
REQ-025 After rst deasserts, the first posedge SHALL commit normally; a reset asserted mid-operation SHALL discard the in-flight write.

Configuration
REQ-026 With macro WB_RF_BYPASS_EN defined, a read port addressing the register being written in the same cycle (nonzero address, any wb_wreg bit set) SHALL return the merged new value combinationally.
REQ-027 With WB_RF_BYPASS_EN undefined, read ports SHALL return the pre-write array value, and hazard forwarding is the ID stage's responsibility.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- LB, vaddr=0x...3, rdata=0x80AABBCC, wreg=4'hF, wraddr=5 -> next cycle r5=0xFFFFFF80, dbg_wdata=0xFFFFFF80.
- r6=0x11223344; LWL k=1, rdata=0xAABBCCDD, wreg=4'b1100 -> r6=0xCCDD3344. Then LWR k=2, wreg=4'b0011 -> r6=0xCCDDAABB.
- Write r0 with wreg=4'hF, data 0xDEADBEEF -> rd_data1(addr 0)=0 and dbg_wen=0.
- With WB_RF_BYPASS_EN, write r7=0x12345678 while rd_addr2=7 -> rd_data2=0x12345678 in the same cycle. With the macro undefined -> the old value that cycle, the new value the next cycle.
- wb_llb_wen=1, wb_llbit=1 together with exc_llb_clr=1 -> llbit=0. Then wb_llb_wen=1 alone -> llbit=1.
- wb_hilo_wen=1, wb_hilo=0x0000000100000002, then assert rst mid-cycle -> hi=lo=0 immediately, and all GPRs read 0.
